scc_mem_responder: RTL and testbench
====================================

// Module: scc_mem_responder
// PURPOSE
//  Memory-side responder for the single-cycle core: unified word-addressed instruction/data store.
//  Serves the fetch port (programCounter -> instruction) and the data port (addressIn/dataOut/writeFlag -> dataIn).
//  On core halt it freezes the store, then streams every word out over a valid/ready dump port for bench checking.
//  Tracks access errors and a run-cycle count.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; legal byte addresses 0 .. 4*DEPTH_WORDS-1
//  INIT_FILE    ""    $readmemh image loaded at time 0; empty string leaves the array uninitialised (X)
// PORTS
//  clk             in   1   core clock
//  rst             in   1   asynchronous reset, active low
//  clk_en          in   1   clock enable; low => no state, counter, write or dump change
//  programCounter  in   32  fetch byte address
//  instruction     out  32  fetched word, combinational
//  addressIn       in   32  data byte address
//  dataOut         in   32  store data from core
//  writeFlag       in   1   store request for this cycle
//  dataIn          out  32  load data to core, combinational
//  halt            in   1   core halt request
//  err_bits        out  2   sticky: [0] fetch error, [1] data error
//  halted          out  1   high once halt has been taken
//  dump_valid      out  1   dump word present
//  dump_ready      in   1   bench accepts dump word
//  dump_addr       out  32  byte address of dump word (index*4)
//  dump_data       out  32  mem[index]
//  dump_done       out  1   all words dumped; held until reset
//  cycle_count     out  32  clk_en cycles spent in RUN
// BEHAVIOUR
//  Addressing: index = addr[31:2]; misaligned = addr[1:0]!=0; out-of-range = index>=DEPTH_WORDS.
//  Reads: instruction = mem[pc index], dataIn = mem[data index], zero-latency; 32'h0 when misaligned/OOR.
//  Writes: posedge clk, clk_en && writeFlag && state==RUN && address legal; illegal stores dropped.
//  Same-cycle read of a location being written returns OLD data; new data visible next cycle.
//  err_bits[0] set on any clk_en RUN cycle with bad PC; err_bits[1] set on bad addressIn with writeFlag.
//  err_bits clear only on reset; loads to bad addresses are not flagged (core drives addressIn always).
//  FSM (clk_en-qualified): RUN -> DRAIN when halt=1; DRAIN -> DUMP next cycle; DUMP -> DONE on
//   handshake of index DEPTH_WORDS-1; DONE terminal until reset.
//  Halt cycle: a store presented with halt=1 still commits; its error check still applies.
//  DRAIN/DUMP/DONE: stores ignored, no err updates, cycle_count frozen, reads stay live.
//  halted=1 in DRAIN/DUMP/DONE. dump_valid=1 only in DUMP; index advances on dump_valid&&dump_ready.
//  dump_addr/dump_data stable while dump_valid && !dump_ready. dump_done=1 only in DONE.
//  cycle_count: +1 per clk_en cycle in RUN, wraps at 2^32.
//  Reset (any state, incl. mid-dump): state RUN, index 0, err_bits 0, halted 0, dump_valid 0,
//   dump_done 0, dump_addr 0, cycle_count 0. Memory array is NOT cleared by reset.
// STRUCTURE
//  Package scc_mem_pkg: state enum (RUN, DRAIN, DUMP, DONE), WORD_BYTES=4, ERR_FETCH=0, ERR_DATA=1.
//  Sub-module scc_mem_dump_seq: index counter + valid/ready handshake + last-word detect.
//  Top holds array, address checks, error flags, cycle counter, FSM.
// TESTING
//  1 Reset, INIT_FILE word0=32'hDEADBEEF, pc=0 -> instruction=32'hDEADBEEF same cycle, err_bits=0.
//  2 Store 32'h12345678 to addr 0x10 with read of 0x10 -> dataIn old value that cycle, 32'h12345678 next.
//  3 Store to addr 0x11, then addr 4*DEPTH_WORDS -> both dropped, err_bits=2'b10; pc=0x2 -> err_bits=2'b11.
//  4 halt with store of 32'hA5A5A5A5 to 0x20 -> committed; halted=1 next cycle; later stores ignored;
//    cycle_count frozen at value counted through halt cycle.
//  5 Dump DEPTH_WORDS=8, dump_ready toggling 1/0 -> 8 handshakes, dump_addr 0..0x1C in order, data held
//    while stalled, dump_done=1 after 8th, stays high.
//  6 rst low during dump word 3, clk_en low during RUN -> all outputs at reset values, memory retained;
//    clk_en=0 cycles add nothing to cycle_count and commit no store.

Source files
------------

// File: rtl/scc_mem_pkg.sv
// Shared types and constants for the single-cycle-core memory responder.
package scc_mem_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ERR_FETCH  = 0;
  localparam int unsigned ERR_DATA   = 1;

  function automatic logic [29:0] word_index(input logic [WORD_W-1:0] addr);
    return addr[31:2];
  endfunction

  function automatic logic misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/scc_mem_dump_seq.sv
// Post-halt dump sequencer: walks word indices under a valid/ready handshake.
module scc_mem_dump_seq
  import scc_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              start,
  input  logic              ready,
  output logic              valid,
  output logic              done,
  output logic [IDX_W-1:0]  index,
  output logic [WORD_W-1:0] addr,
  output logic              last_fire_c
);

  logic is_last;
  logic fire;

  assign is_last     = index == IDX_W'(DEPTH_WORDS - 1);
  assign fire        = clk_en && valid && ready;
  assign last_fire_c = fire && is_last;

  // addr is kept as its own register so the dump address is a clean flop output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      done  <= 1'b0;
      index <= '0;
      addr  <= '0;
    end else if (clk_en) begin
      if (start) begin
        valid <= 1'b1;
        index <= '0;
        addr  <= '0;
      end else if (valid && ready) begin
        if (is_last) begin
          valid <= 1'b0;
          done  <= 1'b1;
        end else begin
          index <= index + IDX_W'(1);
          addr  <= addr + WORD_W'(WORD_BYTES);
        end
      end
    end
  end

endmodule

// File: rtl/scc_mem_responder.sv
// Unified instruction/data store for the single-cycle core with halt-triggered dump.
module scc_mem_responder
  import scc_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [WORD_W-1:0] programCounter,
  output logic [WORD_W-1:0] instruction,
  input  logic [WORD_W-1:0] addressIn,
  input  logic [WORD_W-1:0] dataOut,
  input  logic              writeFlag,
  output logic [WORD_W-1:0] dataIn,
  input  logic              halt,
  output logic [1:0]        err_bits,
  output logic              halted,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [WORD_W-1:0] dump_addr,
  output logic [WORD_W-1:0] dump_data,
  output logic              dump_done,
  output logic [WORD_W-1:0] cycle_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  state_t           state;
  logic             pc_ok;
  logic             data_ok;
  logic             store_en;
  logic             dump_start;
  logic             dump_last;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] data_idx;
  logic [IDX_W-1:0] dump_index;

  assign pc_ok   = !misaligned(programCounter) && (word_index(programCounter) < 30'(DEPTH_WORDS));
  assign data_ok = !misaligned(addressIn) && (word_index(addressIn) < 30'(DEPTH_WORDS));
  assign pc_idx   = programCounter[IDX_W+1:2];
  assign data_idx = addressIn[IDX_W+1:2];

  // Zero-latency reads; illegal addresses return zero rather than aliasing
  assign instruction = pc_ok   ? mem[pc_idx]   : '0;
  assign dataIn      = data_ok ? mem[data_idx] : '0;
  assign dump_data   = mem[dump_index];

  assign store_en   = clk_en && (state == ST_RUN) && writeFlag && data_ok;
  assign dump_start = state == ST_DRAIN;

  // Array has no reset so contents survive a mid-dump reset
  always_ff @(posedge clk) begin
    if (store_en) mem[data_idx] <= dataOut;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      halted      <= 1'b0;
      err_bits    <= '0;
      cycle_count <= '0;
    end else if (clk_en) begin
      case (state)
        ST_RUN: begin
          cycle_count <= cycle_count + WORD_W'(1);
          if (!pc_ok) err_bits[ERR_FETCH] <= 1'b1;
          if (writeFlag && !data_ok) err_bits[ERR_DATA] <= 1'b1;
          if (halt) begin
            state  <= ST_DRAIN;
            halted <= 1'b1;
          end
        end
        ST_DRAIN: state <= ST_DUMP;
        ST_DUMP:  if (dump_last) state <= ST_DONE;
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_RUN;
      endcase
    end
  end

  scc_mem_dump_seq #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_dump_seq (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .start      (dump_start),
    .ready      (dump_ready),
    .valid      (dump_valid),
    .done       (dump_done),
    .index      (dump_index),
    .addr       (dump_addr),
    .last_fire_c(dump_last)
  );

endmodule

// File: tb/tb_scc_mem_responder.sv
// Randomised self-checking bench for scc_mem_responder against a word-array reference model.
module tb_scc_mem_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b1;
  logic [31:0] programCounter = '0;
  logic [31:0] addressIn = '0;
  logic [31:0] dataOut = '0;
  logic        writeFlag = 1'b0;
  logic        halt = 1'b0;
  logic        dump_ready = 1'b0;
  logic [31:0] instruction, dataIn, dump_addr, dump_data, cycle_count;
  logic [1:0]  err_bits;
  logic        halted, dump_valid, dump_done;

  int errors = 0;
  int checks = 0;

  // Reference model: word array, sticky errors, run-cycle count, phase 0..3 = run/drain/dump/done
  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];
  logic [1:0]  err_m = '0;
  logic [31:0] cyc_m = '0;
  int          phase = 0;
  int          k = 0;

  scc_mem_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .programCounter(programCounter), .instruction(instruction),
    .addressIn(addressIn), .dataOut(dataOut), .writeFlag(writeFlag), .dataIn(dataIn),
    .halt(halt), .err_bits(err_bits), .halted(halted),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
  endfunction

  function automatic bit rd_known(input logic [31:0] a);
    if (!legal(a)) return 1'b1;
    return known[int'(a >> 2)];
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (!legal(a)) return 32'h0;
    return mem_m[int'(a >> 2)];
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return 32'(4 * DEPTH) + (32'($urandom) & 32'h0000_FFFC);
    return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  // Apply the spec rules to the model for the inputs present at this edge, then advance
  task automatic tick();
    if (clk_en) begin
      case (phase)
        0: begin
          cyc_m = cyc_m + 32'd1;
          if (!legal(programCounter)) err_m[0] = 1'b1;
          if (writeFlag) begin
            if (legal(addressIn)) begin
              mem_m[int'(addressIn >> 2)] = dataOut;
              known[int'(addressIn >> 2)] = 1'b1;
            end else err_m[1] = 1'b1;
          end
          if (halt) phase = 1;
        end
        1: phase = 2;
        2: if (dump_ready) begin
          if (k == DEPTH - 1) phase = 3;
          else k++;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    err_m = '0;
    cyc_m = '0;
    phase = 0;
    k = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clk_en = 1'b1; writeFlag = 1'b0; halt = 1'b0; dump_ready = 1'b0;
    programCounter = '0; addressIn = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid: got %b want 0", dump_valid); end
    checks++; if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_dump_done: got %b want 0", dump_done); end
    checks++; if (dump_addr !== 32'h0) begin errors++; $display("FAIL reset_dump_addr: got %h want 0", dump_addr); end
    checks++; if (cycle_count !== 32'h0) begin errors++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); end
    checks++; if (err_bits !== 2'b00) begin errors++; $display("FAIL reset_err_bits: got %b want 00", err_bits); end
    rst = 1'b1;
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++) begin
      programCounter = 32'h0;
      addressIn = 32'(i) << 2;
      dataOut = $urandom;
      writeFlag = 1'b1;
      tick();
    end
    writeFlag = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      programCounter = 32'(i) << 2;
      addressIn = 32'(DEPTH - 1 - i) << 2;
      #1;
      checks++; if (instruction !== rd(programCounter)) begin errors++; $display("FAIL preload_fetch[%0d]: got %h want %h", i, instruction, rd(programCounter)); end
      checks++; if (dataIn !== rd(addressIn)) begin errors++; $display("FAIL preload_load[%0d]: got %h want %h", i, dataIn, rd(addressIn)); end
      tick();
    end
  endtask

  task automatic test_fetch_word0();
    programCounter = 32'h0; addressIn = 32'h0; dataOut = 32'hDEADBEEF; writeFlag = 1'b1;
    tick();
    writeFlag = 1'b0;
    #1;
    checks++; if (instruction !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_word0: got %h want deadbeef", instruction); end
    checks++; if (err_bits !== 2'b00) begin errors++; $display("FAIL fetch_word0_err: got %b want 00", err_bits); end
  endtask

  task automatic test_store_old_new();
    logic [31:0] old;
    old = rd(32'h10);
    addressIn = 32'h10; dataOut = 32'h12345678; writeFlag = 1'b1;
    #1;
    checks++; if (dataIn !== old) begin errors++; $display("FAIL store_same_cycle: got %h want %h", dataIn, old); end
    tick();
    writeFlag = 1'b0;
    #1;
    checks++; if (dataIn !== 32'h12345678) begin errors++; $display("FAIL store_next_cycle: got %h want 12345678", dataIn); end
  endtask

  task automatic test_illegal();
    programCounter = 32'h0;
    addressIn = 32'h11; dataOut = 32'hBAD00001; writeFlag = 1'b1;
    tick();
    checks++; if (err_bits !== 2'b10) begin errors++; $display("FAIL misaligned_store_err: got %b want 10", err_bits); end
    addressIn = 32'(4 * DEPTH); dataOut = 32'hBAD00002;
    tick();
    writeFlag = 1'b0;
    addressIn = 32'h10;
    #1;
    checks++; if (err_bits !== 2'b10) begin errors++; $display("FAIL oor_store_err: got %b want 10", err_bits); end
    checks++; if (dataIn !== 32'h12345678) begin errors++; $display("FAIL misaligned_dropped: got %h want 12345678", dataIn); end
    checks++; if (instruction !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_dropped: got %h want deadbeef", instruction); end
    programCounter = 32'h2;
    #1;
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL misaligned_fetch_zero: got %h want 0", instruction); end
    tick();
    checks++; if (err_bits !== 2'b11) begin errors++; $display("FAIL bad_pc_err: got %b want 11", err_bits); end
    programCounter = 32'h0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      programCounter = rand_addr();
      addressIn = rand_addr();
      dataOut = $urandom;
      writeFlag = 1'($urandom_range(0, 1));
      clk_en = ($urandom_range(0, 3) != 0);
      #1;
      if (rd_known(programCounter)) begin
        checks++; if (instruction !== rd(programCounter)) begin errors++; $display("FAIL rand_fetch[%0d]: got %h want %h", i, instruction, rd(programCounter)); end
      end
      if (rd_known(addressIn)) begin
        checks++; if (dataIn !== rd(addressIn)) begin errors++; $display("FAIL rand_load[%0d]: got %h want %h", i, dataIn, rd(addressIn)); end
      end
      tick();
      checks++; if (cycle_count !== cyc_m) begin errors++; $display("FAIL rand_cycle_count[%0d]: got %0d want %0d", i, cycle_count, cyc_m); end
      checks++; if (err_bits !== err_m) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", i, err_bits, err_m); end
    end
    clk_en = 1'b1; writeFlag = 1'b0; programCounter = 32'h0;
  endtask

  task automatic test_halt();
    logic [31:0] cyc_before;
    cyc_before = cyc_m;
    programCounter = 32'h0; addressIn = 32'h1C; dataOut = 32'hA5A5A5A5; writeFlag = 1'b1; halt = 1'b1;
    tick();
    halt = 1'b0;
    dataOut = 32'h11111111;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
    checks++; if (cycle_count !== cyc_before + 32'd1) begin errors++; $display("FAIL halt_cycle_count: got %0d want %0d", cycle_count, cyc_before + 32'd1); end
    checks++; if (dataIn !== 32'hA5A5A5A5) begin errors++; $display("FAIL halt_store_commit: got %h want a5a5a5a5", dataIn); end
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL drain_no_valid: got %b want 0", dump_valid); end
    tick();
  endtask

  task automatic test_dump();
    int n;
    int hs;
    n = 0; hs = 0;
    while (phase == 2 && n < 40) begin
      dump_ready = (n % 2 == 0);
      dataOut = $urandom;
      #1;
      checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL dump_valid[%0d]: got %b want 1", n, dump_valid); end
      checks++; if (dump_addr !== 32'(k * 4)) begin errors++; $display("FAIL dump_addr[%0d]: got %h want %h", n, dump_addr, 32'(k * 4)); end
      checks++; if (dump_data !== mem_m[k]) begin errors++; $display("FAIL dump_data[%0d]: got %h want %h", n, dump_data, mem_m[k]); end
      checks++; if (dataIn !== 32'hA5A5A5A5) begin errors++; $display("FAIL dump_store_ignored[%0d]: got %h want a5a5a5a5", n, dataIn); end
      checks++; if (cycle_count !== cyc_m) begin errors++; $display("FAIL dump_cycle_frozen[%0d]: got %0d want %0d", n, cycle_count, cyc_m); end
      if (dump_ready) hs++;
      tick();
      n++;
    end
    checks++; if (hs != DEPTH) begin errors++; $display("FAIL dump_handshakes: got %0d want %0d", hs, DEPTH); end
    writeFlag = 1'b0; dump_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dump_done !== 1'b1) begin errors++; $display("FAIL dump_done_held[%0d]: got %b want 1", i, dump_done); end
      checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL dump_valid_after[%0d]: got %b want 0", i, dump_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_dump();
    do_reset();
    programCounter = 32'h0; halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    dump_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (dump_addr !== 32'hC) begin errors++; $display("FAIL mid_dump_addr: got %h want c", dump_addr); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_reset_halted: got %b want 0", halted); end
    checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", dump_valid); end
    checks++; if (dump_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_addr: got %h want 0", dump_addr); end
    checks++; if (cycle_count !== 32'h0) begin errors++; $display("FAIL mid_reset_count: got %0d want 0", cycle_count); end
    @(posedge clk);
    #1;
    rst = 1'b1; dump_ready = 1'b0;
    programCounter = 32'h1C;
    #1;
    checks++; if (instruction !== 32'hA5A5A5A5) begin errors++; $display("FAIL mem_retained: got %h want a5a5a5a5", instruction); end
    clk_en = 1'b0; programCounter = 32'h3; addressIn = 32'h18; dataOut = 32'h0BADCAFE; writeFlag = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    writeFlag = 1'b0;
    #1;
    checks++; if (cycle_count !== 32'h0) begin errors++; $display("FAIL clk_en_count: got %0d want 0", cycle_count); end
    checks++; if (err_bits !== 2'b00) begin errors++; $display("FAIL clk_en_err: got %b want 00", err_bits); end
    checks++; if (dataIn !== rd(32'h18)) begin errors++; $display("FAIL clk_en_no_store: got %h want %h", dataIn, rd(32'h18)); end
    clk_en = 1'b1; programCounter = 32'h0;
    tick();
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL clk_en_resume_count: got %0d want 1", cycle_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    programCounter = 32'h2; addressIn = 32'h21; writeFlag = 1'b1;
    tick();
    dump_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (dump_addr !== 32'(i * 4)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, dump_addr, 32'(i * 4)); end
      tick();
    end
    checks++; if (dump_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", dump_done); end
    checks++; if (err_bits !== 2'b00) begin errors++; $display("FAIL halted_err_frozen: got %b want 00", err_bits); end
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL b2b_count: got %0d want 1", cycle_count); end
    writeFlag = 1'b0; programCounter = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    test_reset();
    test_preload();
    test_fetch_word0();
    test_store_old_new();
    test_illegal();
    test_random();
    test_halt();
    test_dump();
    test_reset_mid_dump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
